adxl362_spi_responder: RTL and testbench
========================================

// Module: adxl362_spi_responder
// PURPOSE
//  Synthesizable SPI-slave model of the ADXL362 accelerometer. It answers the same
//  command set the on-board AccelerometerCtl master issues, so the labyrinth design
//  can run with switch- or pattern-driven tilt data when no sensor is present.
//  It sits on the aclSCK/aclMOSI/aclSS/aclMISO nets in place of the real chip and
//  serves X/Y/Z/temperature samples supplied on parallel inputs.
// PARAMETERS
//  SYNC_STAGES  2      flops in each sclk/mosi/ss synchronizer (>=2)
//  PARTID       8'hF2  value returned at address 0x02
//  REVID        8'h01  value returned at address 0x03
// PORTS
//  clk           in   1   system clock, 100 MHz
//  reset         in   1   synchronous, active-high reset
//  sclk          in   1   SPI clock from master, mode 0 (CPOL=0, CPHA=0)
//  mosi          in   1   SPI data from master
//  ss            in   1   SPI select, active low
//  miso          out  1   SPI data to master
//  miso_oe       out  1   high while ss is low; the top level tri-states or ignores miso when low
//  x_in,y_in,z_in in  12  signed 12-bit acceleration samples
//  temp_in       in   12  signed 12-bit temperature sample
//  sample_valid  in   1   one-clk strobe; qualifies x/y/z/temp_in
//  measure_en    out  1   POWER_CTL[1:0]==2'b10
// BEHAVIOUR
//  - Each of sclk, mosi and ss passes through SYNC_STAGES flops. sclk/ss edges are detected on clk.
//    The master's SCLK must be <= clk/8.
//  - MOSI is sampled on the detected sclk rise. MISO shifts MSB-first on the detected sclk fall.
//    MISO updates <= SYNC_STAGES+2 clk after the pin edge.
//  - FSM states: IDLE, CMD, ADDR, DATA, IGNORE.
//  - Detected ss fall: IDLE->CMD. The bit count clears, and x/y/z/temp are snapshotted into
//    shadow registers so multibyte reads are coherent.
//  - CMD completes after 8 bits:
//    - 0x0A (write) or 0x0B (read) -> ADDR.
//    - Any other byte, including 0x0D FIFO read, -> IGNORE and counts as an error.
//  - ADDR completes after 8 bits: the address pointer is loaded with byte[5:0], and the state
//    goes to DATA.
//    - Read: the shift register loads reg[ptr] immediately, so the MSB drives on the 16th fall.
//  - DATA, write: each completed byte writes reg[ptr] if that address is writable, then ptr++.
//  - DATA, read: on each byte boundary, reg[ptr+1] loads and ptr++.
//  - ptr wraps 0x3F->0x00.
//  - IGNORE: miso=0 until ss rises.
//  - Detected ss rise (any state): ->IDLE, miso=0, miso_oe=0.
//    - A partial byte is discarded and is an error if bitcount mod 8 != 0.
//    - Bytes already completed stay committed.
//  - Register map (reads of unlisted addresses return 0x00):
//    - 00 0xAD, 01 0x1D, 02 PARTID, 03 REVID.
//    - 08/09/0A = shadow x/y/z[11:4].
//    - 0B STATUS, bit0 = DATA_READY, other bits 0.
//    - 0E..15 = X_L,X_H,Y_L,Y_H,Z_L,Z_H,T_L,T_H. L = [7:0]; H = {4{s[11]},s[11:8]}.
//    - 20..2E: read/write config bytes, reset value 0x00. 2D = POWER_CTL.
//    - 1F SOFT_RESET: writing 0x52 clears 20..2E and DATA_READY. Other values are ignored.
//  - sample_valid with measure_en=1 updates the live sample regs and sets DATA_READY.
//    With measure_en=0, samples are ignored.
//  - Reading any byte at 08..15 clears DATA_READY at that byte's boundary.
//    If set and clear fall on the same clk, set wins.
//  - sample_valid on the same clk as the detected ss fall: the snapshot captures the new sample.
//  - Reset values: miso=0, miso_oe=0, measure_en=0, FSM=IDLE, ptr=0, DATA_READY=0,
//    config regs 0x00, samples 0.
//  - Reset has priority mid-transaction. After reset the responder stays IDLE until the
//    next ss fall.
// CONFIGURATION
//  ADXL_ERRCNT_EN defined:
//    - 8-bit saturating error counter, readable at 0x3F.
//    - Increments on an unknown command or on a partial byte at ss rise.
//    - Cleared by reset and by SOFT_RESET.
//  ADXL_ERRCNT_EN undefined: no counter logic; 0x3F reads 0x00.
// TESTING
//  1. Read 0x0B,0x00 then 4 bytes -> MISO returns AD,1D,F2,01.
//  2. Write 0x0A,0x2D,0x02 -> measure_en=1; read 0x2D -> 0x02.
//  3. measure_en=1, x_in=12'hF9C, sample_valid pulse -> STATUS=0x01. Read 0x08, 4 bytes ->
//     F9,00,00,00; STATUS then reads 0x00.
//  4. Burst read from 0x0E of 8 bytes with x=12'h123 -> 23,01,.. X_H=0x01. x_in changes
//     mid-burst -> values unchanged within the burst.
//  5. ss raised after 5 bits of the write data byte -> target register unchanged, FSM IDLE.
//     With ADXL_ERRCNT_EN, 0x3F reads 0x01.
//  6. Command 0x0D then 3 bytes -> MISO all 0. Write 0x52 to 0x1F -> 0x2D reads 0x00 and
//     measure_en=0.

Source files
------------

// File: rtl/adxl362_spi_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : adxl362_spi_responder                                             |
// | Desc    : SPI-mode-0 slave answering the ADXL362 command set with samples   |
// |           from parallel inputs. Optional macro: ADXL_ERRCNT_EN (error cnt). |
// | Rev     : 1.0                                                               |
// +----------------------------------------------------------------------------+
module adxl362_spi_responder #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] PARTID      = 8'hF2,
  parameter logic [7:0] REVID       = 8'h01
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sclk,
  input  logic        mosi,
  input  logic        ss,
  output logic        miso,
  output logic        miso_oe,
  input  logic [11:0] x_in,
  input  logic [11:0] y_in,
  input  logic [11:0] z_in,
  input  logic [11:0] temp_in,
  input  logic        sample_valid,
  output logic        measure_en
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CMD    = 3'd1,
    ST_ADDR   = 3'd2,
    ST_DATA   = 3'd3,
    ST_IGNORE = 3'd4
  } state_t;

  localparam logic [7:0] c_CMD_WRITE  = 8'h0A;
  localparam logic [7:0] c_CMD_READ   = 8'h0B;
  localparam logic [7:0] c_SOFT_KEY   = 8'h52;
  localparam logic [5:0] c_ADDR_SOFT  = 6'h1F;

  // ---------------------------------------------------------------- synchronizers
  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic [SYNC_STAGES-1:0] r_ss_sync;
  logic                   r_sclk_d;
  logic                   r_ss_d;

  // ss resets low so a select held low across reset never looks like a new frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sclk_sync <= '0;
      r_mosi_sync <= '0;
      r_ss_sync   <= '0;
      r_sclk_d    <= 1'b0;
      r_ss_d      <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
      r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], ss};
      r_sclk_d    <= r_sclk_sync[SYNC_STAGES-1];
      r_ss_d      <= r_ss_sync[SYNC_STAGES-1];
    end
  end

  logic w_sclk_rise;
  logic w_sclk_fall;
  logic w_ss_rise;
  logic w_ss_fall;
  logic w_mosi;

  assign w_sclk_rise = r_sclk_sync[SYNC_STAGES-1] & ~r_sclk_d;
  assign w_sclk_fall = ~r_sclk_sync[SYNC_STAGES-1] & r_sclk_d;
  assign w_ss_rise   = r_ss_sync[SYNC_STAGES-1] & ~r_ss_d;
  assign w_ss_fall   = ~r_ss_sync[SYNC_STAGES-1] & r_ss_d;
  assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];

  // ---------------------------------------------------------------- state
  state_t      r_state;
  logic [2:0]  r_bitcnt;
  logic [6:0]  r_shift;
  logic [5:0]  r_ptr;
  logic        r_rd;
  logic [7:0]  r_tx;
  logic        r_miso;
  logic        r_miso_oe;

  logic [11:0] r_live_x, r_live_y, r_live_z, r_live_t;
  logic [11:0] r_shd_x, r_shd_y, r_shd_z, r_shd_t;
  logic [7:0]  r_cfg [0:14];
  logic        r_data_ready;

  logic [7:0]  w_byte;
  logic        w_in_frame;
  logic        w_byte_done;
  logic        w_wr_byte;
  logic        w_rd_byte;
  logic        w_soft_rst;
  logic        w_dr_clr;
  logic        w_sample_take;
  logic [5:0]  w_rd_addr;
  logic [7:0]  w_rd_data;
  logic [7:0]  w_errcnt;

  assign w_byte        = {r_shift, w_mosi};
  assign w_in_frame    = (r_state == ST_CMD) || (r_state == ST_ADDR) || (r_state == ST_DATA);
  assign w_byte_done   = w_sclk_rise && (r_bitcnt == 3'd7) && !w_ss_rise && !w_ss_fall && w_in_frame;
  assign w_wr_byte     = w_byte_done && (r_state == ST_DATA) && !r_rd;
  assign w_rd_byte     = w_byte_done && (r_state == ST_DATA) && r_rd;
  assign w_soft_rst    = w_wr_byte && (r_ptr == c_ADDR_SOFT) && (w_byte == c_SOFT_KEY);
  assign w_dr_clr      = w_rd_byte && (r_ptr >= 6'h08) && (r_ptr <= 6'h15);
  assign w_sample_take = sample_valid && measure_en;

  assign measure_en = (r_cfg[13][1:0] == 2'b10);
  assign miso       = r_miso;
  assign miso_oe    = r_miso_oe;

  // The address phase fetches the first byte; afterwards each boundary prefetches ptr+1.
  assign w_rd_addr = (r_state == ST_ADDR) ? w_byte[5:0] : (r_ptr + 6'd1);

  always_comb begin
    w_rd_data = 8'h00;
    case (w_rd_addr)
      6'h00:   w_rd_data = 8'hAD;
      6'h01:   w_rd_data = 8'h1D;
      6'h02:   w_rd_data = PARTID;
      6'h03:   w_rd_data = REVID;
      6'h08:   w_rd_data = r_shd_x[11:4];
      6'h09:   w_rd_data = r_shd_y[11:4];
      6'h0A:   w_rd_data = r_shd_z[11:4];
      6'h0B:   w_rd_data = {7'd0, r_data_ready};
      6'h0E:   w_rd_data = r_shd_x[7:0];
      6'h0F:   w_rd_data = {{4{r_shd_x[11]}}, r_shd_x[11:8]};
      6'h10:   w_rd_data = r_shd_y[7:0];
      6'h11:   w_rd_data = {{4{r_shd_y[11]}}, r_shd_y[11:8]};
      6'h12:   w_rd_data = r_shd_z[7:0];
      6'h13:   w_rd_data = {{4{r_shd_z[11]}}, r_shd_z[11:8]};
      6'h14:   w_rd_data = r_shd_t[7:0];
      6'h15:   w_rd_data = {{4{r_shd_t[11]}}, r_shd_t[11:8]};
      6'h3F:   w_rd_data = w_errcnt;
      default: begin
        if ((w_rd_addr >= 6'h20) && (w_rd_addr <= 6'h2E)) begin
          w_rd_data = r_cfg[w_rd_addr[3:0]];
        end
      end
    endcase
  end

  // ---------------------------------------------------------------- samples
  // A sample arriving on the ss-fall clock must land in the snapshot.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_live_x <= '0;
      r_live_y <= '0;
      r_live_z <= '0;
      r_live_t <= '0;
      r_shd_x  <= '0;
      r_shd_y  <= '0;
      r_shd_z  <= '0;
      r_shd_t  <= '0;
    end else begin
      if (w_sample_take) begin
        r_live_x <= x_in;
        r_live_y <= y_in;
        r_live_z <= z_in;
        r_live_t <= temp_in;
      end
      if (w_ss_fall) begin
        r_shd_x <= w_sample_take ? x_in    : r_live_x;
        r_shd_y <= w_sample_take ? y_in    : r_live_y;
        r_shd_z <= w_sample_take ? z_in    : r_live_z;
        r_shd_t <= w_sample_take ? temp_in : r_live_t;
      end
    end
  end

  // ---------------------------------------------------------------- config / status
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 15; i++) r_cfg[i] <= 8'h00;
      r_data_ready <= 1'b0;
    end else begin
      if (w_soft_rst) begin
        for (int i = 0; i < 15; i++) r_cfg[i] <= 8'h00;
      end else if (w_wr_byte && (r_ptr >= 6'h20) && (r_ptr <= 6'h2E)) begin
        r_cfg[r_ptr[3:0]] <= w_byte;
      end
      if (w_sample_take) begin
        r_data_ready <= 1'b1;
      end else if (w_dr_clr || w_soft_rst) begin
        r_data_ready <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------- error counter
`ifdef ADXL_ERRCNT_EN
  logic       w_err;
  logic [7:0] r_errcnt;

  assign w_err = (w_ss_rise && (r_state != ST_IDLE) && (r_bitcnt != 3'd0)) ||
                 (w_byte_done && (r_state == ST_CMD) &&
                  (w_byte != c_CMD_WRITE) && (w_byte != c_CMD_READ));

  always_ff @(posedge clk) begin
    if (reset || w_soft_rst) begin
      r_errcnt <= 8'h00;
    end else if (w_err && (r_errcnt != 8'hFF)) begin
      r_errcnt <= r_errcnt + 8'd1;
    end
  end

  assign w_errcnt = r_errcnt;
`else
  assign w_errcnt = 8'h00;
`endif

  // ---------------------------------------------------------------- protocol FSM
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_bitcnt  <= 3'd0;
      r_shift   <= 7'd0;
      r_ptr     <= 6'd0;
      r_rd      <= 1'b0;
      r_tx      <= 8'h00;
      r_miso    <= 1'b0;
      r_miso_oe <= 1'b0;
    end else if (w_ss_rise) begin
      r_state   <= ST_IDLE;
      r_bitcnt  <= 3'd0;
      r_miso    <= 1'b0;
      r_miso_oe <= 1'b0;
    end else if (w_ss_fall) begin
      r_state   <= ST_CMD;
      r_bitcnt  <= 3'd0;
      r_miso    <= 1'b0;
      r_miso_oe <= 1'b1;
    end else if (r_state != ST_IDLE) begin
      if (w_sclk_rise) begin
        r_bitcnt <= r_bitcnt + 3'd1;
        r_shift  <= w_byte[6:0];
        if (r_bitcnt == 3'd7) begin
          case (r_state)
            ST_CMD: begin
              if (w_byte == c_CMD_WRITE) begin
                r_rd    <= 1'b0;
                r_state <= ST_ADDR;
              end else if (w_byte == c_CMD_READ) begin
                r_rd    <= 1'b1;
                r_state <= ST_ADDR;
              end else begin
                r_state <= ST_IGNORE;
              end
            end
            ST_ADDR: begin
              r_ptr   <= w_byte[5:0];
              r_tx    <= w_rd_data;
              r_state <= ST_DATA;
            end
            ST_DATA: begin
              r_ptr <= r_ptr + 6'd1;
              if (r_rd) r_tx <= w_rd_data;
            end
            default: ;
          endcase
        end
      end else if (w_sclk_fall) begin
        if ((r_state == ST_DATA) && r_rd) begin
          r_miso <= r_tx[7];
          r_tx   <= {r_tx[6:0], 1'b0};
        end else begin
          r_miso <= 1'b0;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_adxl362_spi_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_adxl362_spi_responder                                          |
// | Desc    : Directed SPI transactions against a register-map reference model. |
// | Rev     : 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_adxl362_spi_responder;
  localparam int H = 50;  // SCLK half period in ns (SCLK = clk/10)

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sclk = 1'b0;
  logic        mosi = 1'b0;
  logic        ss = 1'b1;
  logic        sample_valid = 1'b0;
  logic [11:0] x_in = '0, y_in = '0, z_in = '0, temp_in = '0;
  logic        miso, miso_oe, measure_en;

  always #5 clk = ~clk;

  adxl362_spi_responder dut (
    .clk(clk), .reset(reset), .sclk(sclk), .mosi(mosi), .ss(ss),
    .miso(miso), .miso_oe(miso_oe),
    .x_in(x_in), .y_in(y_in), .z_in(z_in), .temp_in(temp_in),
    .sample_valid(sample_valid), .measure_en(measure_en)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [7:0] got;
    logic [7:0] mexp;
    logic [7:0] lexp;
    bit         lv;
    int         tag;
  } cmp_t;
  cmp_t cq[$];
  bit chk_idle = 1'b0;
  bit chk_oe   = 1'b0;

  // reference register map
  logic [7:0]  m_cfg  [0:14];
  logic [11:0] m_live [0:3];
  logic [11:0] m_shd  [0:3];
  bit          m_dr;
  int          m_err;

  function automatic bit m_me();
    return (m_cfg[13][1:0] == 2'b10);
  endfunction

  function automatic logic [7:0] m_read(input logic [5:0] a);
    int ai;
    ai = int'(a);
    if (ai == 0) return 8'hAD;
    if (ai == 1) return 8'h1D;
    if (ai == 2) return 8'hF2;
    if (ai == 3) return 8'h01;
    if (ai >= 8 && ai <= 10) return m_shd[ai-8][11:4];
    if (ai == 11) return {7'd0, m_dr};
    if (ai >= 14 && ai <= 21) begin
      logic [11:0] s;
      s = m_shd[(ai-14)/2];
      if (ai % 2 == 0) return s[7:0];
      return {{4{s[11]}}, s[11:8]};
    end
    if (ai >= 32 && ai <= 46) return m_cfg[ai-32];
`ifdef ADXL_ERRCNT_EN
    if (ai == 63) return m_err[7:0];
`endif
    return 8'h00;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 15; i++) m_cfg[i] = 8'h00;
    for (int i = 0; i < 4; i++) begin m_live[i] = '0; m_shd[i] = '0; end
    m_dr = 1'b0;
    m_err = 0;
  endtask

  task automatic m_error();
    if (m_err < 255) m_err++;
  endtask

  task automatic m_write(input logic [5:0] a, input logic [7:0] v);
    if (a >= 6'h20 && a <= 6'h2E) m_cfg[int'(a)-32] = v;
    else if (a == 6'h1F && v == 8'h52) begin
      for (int i = 0; i < 15; i++) m_cfg[i] = 8'h00;
      m_dr = 1'b0;
      m_err = 0;
    end
  endtask

  // single compare process: idle outputs, select-active oe, and every queued byte
  always @(negedge clk) begin
    if (chk_idle) begin
      n_cmp++;
      if (miso !== 1'b0 || miso_oe !== 1'b0 || measure_en !== m_me()) begin
        n_bad++;
        if (n_bad < 20)
          $display("FAIL idle t=%0t miso=%b oe=%b measure_en=%b want 0/0/%b",
                   $time, miso, miso_oe, measure_en, m_me());
      end
    end
    if (chk_oe) begin
      n_cmp++;
      if (miso_oe !== 1'b1) begin
        n_bad++;
        if (n_bad < 20) $display("FAIL miso_oe t=%0t got=%b want=1", $time, miso_oe);
      end
    end
    while (cq.size() > 0) begin
      cmp_t c;
      c = cq.pop_front();
      n_cmp++;
      if (c.got !== c.mexp) begin
        n_bad++;
        $display("FAIL model tag=%0d got=%02h want=%02h", c.tag, c.got, c.mexp);
      end
      if (c.lv) begin
        n_cmp++;
        if (c.got !== c.lexp) begin
          n_bad++;
          $display("FAIL literal tag=%0d got=%02h want=%02h", c.tag, c.got, c.lexp);
        end
      end
    end
  end

  // transaction buffers
  logic [7:0] tx_b  [0:15];
  logic [7:0] lit_b [0:15];
  bit         lit_v [0:15];
  logic [7:0] exp_b [0:16];
  int         inj_at = -1;
  int         cur_tag = 0;

  task automatic push_cmp(input logic [7:0] got, input logic [7:0] mexp,
                          input logic [7:0] lexp, input bit lv, input int tag);
    cmp_t c;
    c.got = got; c.mexp = mexp; c.lexp = lexp; c.lv = lv; c.tag = tag;
    cq.push_back(c);
  endtask

  task automatic chk_me(input bit want);
    cur_tag++;
    push_cmp({7'd0, measure_en}, {7'd0, m_me()}, {7'd0, want}, 1'b1, cur_tag * 100);
  endtask

  task automatic pulse_sample();
    @(posedge clk); #1 sample_valid = 1'b1;
    if (m_me()) begin
      m_live[0] = x_in; m_live[1] = y_in; m_live[2] = z_in; m_live[3] = temp_in;
      m_dr = 1'b1;
    end
    @(posedge clk); #1 sample_valid = 1'b0;
  endtask

  task automatic lit(input int slot, input logic [7:0] v);
    lit_b[slot] = v;
    lit_v[slot] = 1'b1;
  endtask

  task automatic xfer(input int nbytes, input int tail);
    logic [7:0] rx;
    int         mstate;
    bit         mrd;
    logic [5:0] mptr;
    int         nb;
    cur_tag++;
    chk_idle = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 17; i++) exp_b[i] = 8'h00;
    for (int i = 0; i < 4; i++) m_shd[i] = m_live[i];
    mstate = 0; mrd = 1'b0; mptr = 6'd0;
    ss = 1'b0;
    #(H);
    chk_oe = 1'b1;
    for (int b = 0; b < nbytes + ((tail > 0) ? 1 : 0); b++) begin
      nb = (b < nbytes) ? 8 : tail;
      if (b == inj_at) pulse_sample();
      rx = 8'h00;
      for (int k = 0; k < nb; k++) begin
        mosi = tx_b[b][7-k];
        #(H);
        rx = {rx[6:0], miso};
        sclk = 1'b1;
        #(H);
        sclk = 1'b0;
      end
      if (nb == 8) begin
        push_cmp(rx, exp_b[b], lit_b[b], lit_v[b], cur_tag * 100 + b);
        case (mstate)
          0: begin
            if (tx_b[b] == 8'h0A) begin mrd = 1'b0; mstate = 1; end
            else if (tx_b[b] == 8'h0B) begin mrd = 1'b1; mstate = 1; end
            else begin mstate = 3; m_error(); end
          end
          1: begin
            mptr = tx_b[b][5:0];
            mstate = 2;
            if (mrd) exp_b[b+1] = m_read(mptr);
          end
          2: begin
            if (mrd) begin
              exp_b[b+1] = m_read(mptr + 6'd1);
              if (mptr >= 6'h08 && mptr <= 6'h15) m_dr = 1'b0;
            end else begin
              m_write(mptr, tx_b[b]);
            end
            mptr = mptr + 6'd1;
          end
          default: ;
        endcase
      end else begin
        m_error();
      end
    end
    #(H);
    chk_oe = 1'b0;
    ss = 1'b1;
    mosi = 1'b0;
    repeat (10) @(posedge clk);
    #1 chk_idle = 1'b1;
    for (int i = 0; i < 16; i++) begin lit_v[i] = 1'b0; tx_b[i] = 8'h00; end
    inj_at = -1;
  endtask

  task automatic wr(input logic [5:0] a, input logic [7:0] v);
    tx_b[0] = 8'h0A; tx_b[1] = {2'b00, a}; tx_b[2] = v;
    xfer(3, 0);
  endtask

  task automatic rd(input logic [5:0] a, input int n);
    tx_b[0] = 8'h0B; tx_b[1] = {2'b00, a};
    xfer(n + 2, 0);
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 16; i++) begin tx_b[i] = 8'h00; lit_v[i] = 1'b0; lit_b[i] = 8'h00; end
    m_reset();
    repeat (3) @(posedge clk);
    #1 chk_idle = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (10) @(posedge clk);

    // identification registers
    lit(2, 8'hAD); lit(3, 8'h1D); lit(4, 8'hF2); lit(5, 8'h01);
    rd(6'h00, 4);

    // enter measurement mode
    wr(6'h2D, 8'h02);
    chk_me(1'b1);
    lit(2, 8'h02); rd(6'h2D, 1);

    // DATA_READY and 8-bit X
    x_in = 12'hF9C; y_in = 12'h000; z_in = 12'h000; temp_in = 12'h000;
    pulse_sample();
    lit(2, 8'h01); rd(6'h0B, 1);
    pulse_sample();
    lit(2, 8'hF9); lit(3, 8'h00); lit(4, 8'h00); lit(5, 8'h00);
    rd(6'h08, 4);
    lit(2, 8'h00); rd(6'h0B, 1);

    // coherent burst with a new sample arriving mid-burst
    x_in = 12'h123; y_in = 12'h7A5; z_in = 12'h800; temp_in = 12'h0FF;
    pulse_sample();
    x_in = 12'h555; y_in = 12'h0AA; z_in = 12'h001; temp_in = 12'hF00;
    inj_at = 4;
    lit(2, 8'h23); lit(3, 8'h01); lit(4, 8'hA5); lit(5, 8'h07);
    lit(6, 8'h00); lit(7, 8'hF8); lit(8, 8'hFF); lit(9, 8'h00);
    rd(6'h0E, 8);
    lit(2, 8'h55); lit(3, 8'h05); rd(6'h0E, 2);

    // partial write byte is discarded
    wr(6'h20, 8'hAB);
    tx_b[0] = 8'h0A; tx_b[1] = 8'h20; tx_b[2] = 8'h11;
    xfer(2, 5);
    lit(2, 8'hAB); rd(6'h20, 1);
`ifdef ADXL_ERRCNT_EN
    lit(2, 8'h01);
`else
    lit(2, 8'h00);
`endif
    rd(6'h3F, 1);

    // unknown command, then soft reset
    tx_b[0] = 8'h0D;
    lit(1, 8'h00); lit(2, 8'h00); lit(3, 8'h00);
    xfer(4, 0);
    wr(6'h1F, 8'h52);
    lit(2, 8'h00); rd(6'h2D, 1);
    chk_me(1'b0);
    lit(2, 8'h00); rd(6'h20, 1);

    // pointer wrap 3E -> 3F -> 00, read-only write ignored, multibyte write
    lit(3, 8'h00); lit(4, 8'hAD); rd(6'h3E, 3);
    wr(6'h00, 8'h55);
    lit(2, 8'hAD); rd(6'h00, 1);
    tx_b[0] = 8'h0A; tx_b[1] = 8'h21; tx_b[2] = 8'h11; tx_b[3] = 8'h22; tx_b[4] = 8'h33;
    xfer(5, 0);
    lit(2, 8'h11); lit(3, 8'h22); lit(4, 8'h33); rd(6'h21, 3);

    // samples ignored while not measuring
    x_in = 12'h777;
    pulse_sample();
    lit(2, 8'h00); rd(6'h0B, 1);
    lit(2, 8'h55); rd(6'h0E, 1);

    // reset in the middle of a transaction
    wr(6'h2D, 8'h02);
    chk_me(1'b1);
    chk_idle = 1'b0;
    @(posedge clk); #1 ss = 1'b0;
    #(H);
    for (int k = 0; k < 12; k++) begin
      mosi = 1'b1; #(H); sclk = 1'b1; #(H); sclk = 1'b0;
    end
    reset = 1'b1;
    m_reset();
    repeat (4) @(posedge clk);
    #1 reset = 1'b0;
    repeat (5) @(posedge clk);
    #1 ss = 1'b1; mosi = 1'b0;
    repeat (10) @(posedge clk);
    #1 chk_idle = 1'b1;
    chk_me(1'b0);
    lit(2, 8'h00); rd(6'h2D, 1);
    lit(2, 8'hAD); lit(3, 8'h1D); rd(6'h00, 2);

    repeat (5) @(posedge clk);
    chk_idle = 1'b0;
    @(negedge clk);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
